edge_point_reader: RTL and testbench

//  Reader side of the edge BRAM filled by the Sobel stage. After the edge map is complete,

---
 rtl/edge_pkg.sv | 22 ++
 rtl/edge_bbox_tracker.sv | 36 +++
 rtl/edge_point_reader.sv | 144 ++++++++++++++
 tb/tb_edge_point_reader.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_pkg.sv
// Shared definitions for the edge BRAM reader: geometry defaults, bus widths and FSM states.
package edge_pkg;

    localparam int DEFAULT_WIDTH  = 640;
    localparam int DEFAULT_HEIGHT = 480;
    localparam int ADDR_W         = 19;
    localparam int X_W            = 10;
    localparam int Y_W            = 9;
    localparam int EDGE_W         = 3;
    localparam int BRAM_LATENCY   = 2;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        WAIT2,
        CHECK,
        EMIT,
        ADVANCE,
        DONE
    } state_t;

endpackage

// File: rtl/edge_bbox_tracker.sv
// Bounding box of the edge pixels seen in the current scan; cleared at scan start,
// widened on each update strobe.
module edge_bbox_tracker
    import edge_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int HEIGHT = DEFAULT_HEIGHT
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clear,
    input  logic           update,
    input  logic [X_W-1:0] x,
    input  logic [Y_W-1:0] y,
    output logic [X_W-1:0] x_min,
    output logic [X_W-1:0] x_max,
    output logic [Y_W-1:0] y_min,
    output logic [Y_W-1:0] y_max
);

    // Min starts at the far corner and max at the origin so the first update wins both.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            x_min <= X_W'(WIDTH - 1);
            x_max <= '0;
            y_min <= Y_W'(HEIGHT - 1);
            y_max <= '0;
        end else if (update) begin
            if (x < x_min) x_min <= x;
            if (x > x_max) x_max <= x;
            if (y < y_min) y_min <= y;
            if (y > y_max) y_max <= y;
        end
    end

endmodule

// File: rtl/edge_point_reader.sv
// Raster-scans the completed edge BRAM and streams (x,y) of every nonzero pixel on a
// valid/ready interface. Optional bounding box output enabled by EDGE_READER_BBOX_EN.
module edge_point_reader
    import edge_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int HEIGHT = DEFAULT_HEIGHT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [EDGE_W-1:0] edge_data,
    output logic [ADDR_W-1:0] edge_memory_addr,
    output logic [X_W-1:0]    point_x,
    output logic [Y_W-1:0]    point_y,
    output logic              point_valid,
    input  logic              point_ready,
    output logic [ADDR_W-1:0] point_count,
    output logic              done
`ifdef EDGE_READER_BBOX_EN
    ,
    output logic [X_W-1:0]    bbox_x_min,
    output logic [X_W-1:0]    bbox_x_max,
    output logic [Y_W-1:0]    bbox_y_min,
    output logic [Y_W-1:0]    bbox_y_max,
    output logic              bbox_valid
`endif
);

    state_t         state;
    state_t         next_state;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           last_pixel;
    logic           scan_start;
    logic           edge_hit;

    assign last_pixel = (x == X_W'(WIDTH - 1)) && (y == Y_W'(HEIGHT - 1));
    assign scan_start = (state == IDLE) && start;
    assign edge_hit   = (state == CHECK) && (edge_data != '0);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // WAIT/WAIT2 cover the two-cycle BRAM read latency before CHECK samples edge_data.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = WAIT;
            WAIT:    next_state = WAIT2;
            WAIT2:   next_state = CHECK;
            CHECK:   next_state = (edge_data != '0) ? EMIT : ADVANCE;
            EMIT:    if (point_ready) next_state = ADVANCE;
            ADVANCE: next_state = last_pixel ? DONE : WAIT;
            DONE:    if (!start) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            edge_memory_addr <= '0;
            x                <= '0;
            y                <= '0;
            point_x          <= '0;
            point_y          <= '0;
            point_valid      <= 1'b0;
            point_count      <= '0;
            done             <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        edge_memory_addr <= '0;
                        x                <= '0;
                        y                <= '0;
                        point_count      <= '0;
                        done             <= 1'b0;
                    end
                end
                CHECK: begin
                    if (edge_data != '0) begin
                        point_x     <= x;
                        point_y     <= y;
                        point_valid <= 1'b1;
                    end
                end
                EMIT: begin
                    if (point_ready) begin
                        point_valid <= 1'b0;
                        point_count <= point_count + ADDR_W'(1);
                    end
                end
                ADVANCE: begin
                    // The address stops at the last pixel so it never leaves the frame.
                    if (last_pixel) begin
                        done <= 1'b1;
                    end else begin
                        edge_memory_addr <= edge_memory_addr + ADDR_W'(1);
                        if (x == X_W'(WIDTH - 1)) begin
                            x <= '0;
                            y <= y + Y_W'(1);
                        end else begin
                            x <= x + X_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef EDGE_READER_BBOX_EN
    edge_bbox_tracker #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) bbox_tracker (
        .clk    (clk),
        .reset  (reset),
        .clear  (scan_start),
        .update (edge_hit),
        .x      (x),
        .y      (y),
        .x_min  (bbox_x_min),
        .x_max  (bbox_x_max),
        .y_min  (bbox_y_min),
        .y_max  (bbox_y_max)
    );

    // An empty frame has no meaningful box, so validity follows the transfer count.
    always_ff @(posedge clk) begin
        if (reset || scan_start)
            bbox_valid <= 1'b0;
        else if (state == ADVANCE && last_pixel)
            bbox_valid <= (point_count != '0);
    end
`else
    logic unused_hit;
    assign unused_hit = edge_hit;
`endif

endmodule

// File: tb/tb_edge_point_reader.sv
// Directed, table-driven bench for edge_point_reader on an 8x4 frame with a 2-cycle BRAM model.
// Bounding box checks are compiled in when EDGE_READER_BBOX_EN is defined.
module tb_edge_point_reader;

    localparam int W = 8;
    localparam int H = 4;
    localparam int NPIX = W * H;
    localparam int BUDGET = 400;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  edge_data;
    logic [18:0] edge_memory_addr;
    logic [9:0]  point_x;
    logic [8:0]  point_y;
    logic        point_valid;
    logic        point_ready;
    logic [18:0] point_count;
    logic        done;
`ifdef EDGE_READER_BBOX_EN
    logic [9:0]  bbox_x_min, bbox_x_max;
    logic [8:0]  bbox_y_min, bbox_y_max;
    logic        bbox_valid;
`endif

    logic [2:0]  mem [NPIX];
    logic [2:0]  bram_stage;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] mask;
        int          stall;
        int          exp_count;
        int          exp_cycles;
        int          bx_min, bx_max, by_min, by_max;
        bit          bvalid;
    } vec_t;

    vec_t vecs [5];

    edge_point_reader #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .edge_data        (edge_data),
        .edge_memory_addr (edge_memory_addr),
        .point_x          (point_x),
        .point_y          (point_y),
        .point_valid      (point_valid),
        .point_ready      (point_ready),
        .point_count      (point_count),
        .done             (done)
`ifdef EDGE_READER_BBOX_EN
        ,
        .bbox_x_min       (bbox_x_min),
        .bbox_x_max       (bbox_x_max),
        .bbox_y_min       (bbox_y_min),
        .bbox_y_max       (bbox_y_max),
        .bbox_valid       (bbox_valid)
`endif
    );

    always #5 clk = ~clk;

    // Two register stages between address and data, like the real edge BRAM.
    always @(posedge clk) begin
        bram_stage <= mem[edge_memory_addr[4:0]];
        edge_data  <= bram_stage;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic r, input logic rst);
        @(negedge clk);
        start       = s;
        point_ready = r;
        reset       = rst;
    endtask

    task automatic loadMap(input logic [31:0] mask);
        for (int i = 0; i < NPIX; i++)
            mem[i] = mask[i] ? 3'(1 + (i % 7)) : 3'd0;
    endtask

    // Called just after a negedge with the FSM in IDLE; start is sampled on the next edge.
    task automatic runScan(input vec_t v);
        int          cyc;
        int          xfers;
        int          next_idx;
        int          stall_left;
        int          max_addr;
        bit          in_emit;
        logic [9:0]  hold_x;
        logic [8:0]  hold_y;
        logic [18:0] hold_addr;

        loadMap(v.mask);
        start       = 1'b1;
        point_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("start_clears_done", 32'(done), 32'd0);
        checkOutput("count_restart", 32'(point_count), 32'd0);

        cyc = 0; xfers = 0; next_idx = 0; stall_left = 0; max_addr = 0; in_emit = 0;
        hold_x = '0; hold_y = '0; hold_addr = '0;
        while (cyc <= BUDGET && !done) begin
            if (int'(edge_memory_addr) > max_addr) max_addr = int'(edge_memory_addr);
            if (point_valid) begin
                if (!in_emit) begin
                    in_emit    = 1;
                    stall_left = v.stall;
                    hold_x     = point_x;
                    hold_y     = point_y;
                    hold_addr  = edge_memory_addr;
                end else begin
                    checkOutput("stall_x_stable", 32'(point_x), 32'(hold_x));
                    checkOutput("stall_y_stable", 32'(point_y), 32'(hold_y));
                    checkOutput("stall_addr_stable", 32'(edge_memory_addr), 32'(hold_addr));
                end
                if (stall_left > 0) begin
                    point_ready = 1'b0;
                    stall_left--;
                end else begin
                    point_ready = 1'b1;
                    while (next_idx < NPIX && !v.mask[next_idx]) next_idx++;
                    checkOutput("point_x", 32'(point_x), 32'(next_idx % W));
                    checkOutput("point_y", 32'(point_y), 32'(next_idx / W));
                    next_idx++;
                    xfers++;
                    in_emit = 0;
                end
            end else begin
                if (in_emit) begin
                    checkOutput("valid_dropped_in_stall", 32'd0, 32'd1);
                    in_emit = 0;
                end
                point_ready = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end

        if (!done) checkOutput("done_timeout", 32'(cyc), 32'(v.exp_cycles));
        checkOutput("done_cycles", 32'(cyc), 32'(v.exp_cycles));
        checkOutput("transfers", 32'(xfers), 32'(v.exp_count));
        checkOutput("point_count", 32'(point_count), 32'(v.exp_count));
        checkOutput("addr_max", 32'(max_addr), 32'(NPIX - 1));
`ifdef EDGE_READER_BBOX_EN
        checkOutput("bbox_valid", 32'(bbox_valid), 32'(v.bvalid));
        if (v.bvalid) begin
            checkOutput("bbox_x_min", 32'(bbox_x_min), 32'(v.bx_min));
            checkOutput("bbox_x_max", 32'(bbox_x_max), 32'(v.bx_max));
            checkOutput("bbox_y_min", 32'(bbox_y_min), 32'(v.by_min));
            checkOutput("bbox_y_max", 32'(bbox_y_max), 32'(v.by_max));
        end
`endif
    endtask

    initial begin
        int   hold_bad;
        bit   reached;
        vec_t rv;

        // Expected cycle counts: 4 per pixel, +1 per edge pixel, +stall cycles per edge pixel.
        vecs[0] = '{32'h0000_0000, 0, 0, 128, 7, 0, 3, 0, 0};
        vecs[1] = '{(32'd1 << 0) | (32'd1 << 7) | (32'd1 << 19) | (32'd1 << 31), 0, 4, 132, 0, 7, 0, 3, 1};
        vecs[2] = '{32'd1 << 13, 10, 1, 139, 5, 5, 1, 1, 1};
        vecs[3] = '{(32'd1 << 10) | (32'd1 << 30), 0, 2, 130, 2, 6, 1, 3, 1};
        vecs[4] = '{(32'd1 << 0) | (32'd1 << 31), 2, 2, 134, 0, 7, 0, 3, 1};

        reset = 1'b1; start = 1'b0; point_ready = 1'b0;
        loadMap(32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_valid", 32'(point_valid), 32'd0);
        checkOutput("reset_addr", 32'(edge_memory_addr), 32'd0);
        checkOutput("reset_x", 32'(point_x), 32'd0);
        checkOutput("reset_y", 32'(point_y), 32'd0);
        checkOutput("reset_count", 32'(point_count), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            @(posedge clk);
            @(negedge clk);
            if (i > 0) checkOutput("done_hold_idle", 32'(done), 32'd1);
            $display("[TB] scan vector %0d", i);
            runScan(vecs[i]);
        end

        // start still high after done: no rescan may begin.
        hold_bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (!done || point_valid || edge_memory_addr != 19'(NPIX - 1)) hold_bad++;
        end
        checkOutput("hold_no_rescan", 32'(hold_bad), 32'd0);
        checkOutput("hold_count", 32'(point_count), 32'(vecs[4].exp_count));

        // Reset while EMIT is stalled, then rescan from the origin.
        rv = vecs[2];
        rv.stall = 0;
        rv.exp_cycles = 129;
        loadMap(rv.mask);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        reached = 0;
        for (int c = 0; c < BUDGET && !reached; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (point_valid) reached = 1;
        end
        checkOutput("reach_emit", 32'(reached), 32'd1);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        checkOutput("stalled_x", 32'(point_x), 32'd5);
        checkOutput("stalled_y", 32'(point_y), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort_valid", 32'(point_valid), 32'd0);
        checkOutput("abort_addr", 32'(edge_memory_addr), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_count", 32'(point_count), 32'd0);
        reset = 1'b0;
        point_ready = 1'b1;
        runScan(rv);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
